// File: rtl/neuron_spike_in.sv
// Wishbone-fed spike FIFO that streams 32-bit spike vectors into the neuron core.
// Optional drop counter at offset 0xC is built only when NEURON_SPIKE_IN_DROPCNT_EN is defined.
module neuron_spike_in #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_3000,
  parameter int          DEPTH     = 8
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic [31:0] spike_data_o,
  output logic        spike_valid_o,
  input  logic        spike_ready_i
);
  localparam int            AW       = $clog2(DEPTH);
  localparam int            CW       = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [31:0]   offs;
  logic          in_win;
  logic          req;
  logic [1:0]    reg_idx;
  logic          wr_data;
  logic          wr_stat;
  logic          wr_ctrl;
  logic          full_word;
  logic          flush;
  logic          push;
  logic          pop;
  logic          drop;
  logic          empty;
  logic          full;
  logic          enable;
  logic          overflow;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] rd_next;
  logic [CW-1:0] count;
  logic [CW-1:0] cnt_after_pop;
  logic [4:0]    count_ext;
  logic [31:0]   drop_rd;
  logic [31:0]   rd_mux;
  logic [31:0]   head_nxt;
  logic [31:0]   mem [DEPTH];
  logic          unused_offs;

  assign offs        = wbs_adr_i - BASE_ADDR;
  assign in_win      = (offs[31:4] == 28'h0);
  assign unused_offs = &{1'b0, offs[1:0]};
  assign reg_idx     = offs[3:2];
  assign req         = wbs_cyc_i & wbs_stb_i & in_win & ~wbs_ack_o;

  assign wr_data   = req & wbs_we_i & (reg_idx == 2'd0);
  assign wr_stat   = req & wbs_we_i & (reg_idx == 2'd1);
  assign wr_ctrl   = req & wbs_we_i & (reg_idx == 2'd2);
  assign full_word = (wbs_sel_i == 4'hF);
  assign flush     = wr_stat & wbs_dat_i[0];

  assign empty         = (count == '0);
  assign full          = (count == FULL_CNT);
  assign spike_valid_o = enable & ~empty;
  assign pop           = spike_valid_o & spike_ready_i;
  // A full FIFO still accepts a word when the head leaves on the same edge.
  assign push          = wr_data & full_word & (~full | pop);
  assign drop          = wr_data & full_word & full & ~pop;
  assign rd_next       = rd_ptr + AW'(pop);
  assign cnt_after_pop = count - CW'(pop);
  assign count_ext     = 5'(count);

`ifdef NEURON_SPIKE_IN_DROPCNT_EN
  logic       wr_drop;
  logic [7:0] drop_cnt;

  assign wr_drop = req & wbs_we_i & (reg_idx == 2'd3);
  assign drop_rd = {24'h0, drop_cnt};

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i)
      drop_cnt <= 8'h0;
    else if (wr_drop)
      drop_cnt <= 8'h0;
    else if (drop && drop_cnt != 8'hFF)
      drop_cnt <= drop_cnt + 8'h1;
  end
`else
  assign drop_rd = 32'h0;
`endif

  always_comb begin
    rd_mux = 32'h0;
    case (reg_idx)
      2'd1:    rd_mux = {23'h0, count_ext, 1'b0, overflow, full, empty};
      2'd2:    rd_mux = {31'h0, enable};
      2'd3:    rd_mux = drop_rd;
      default: rd_mux = 32'h0;
    endcase
  end

  // Next head word: a push into a FIFO that empties this edge bypasses the array.
  always_comb begin
    head_nxt = 32'h0;
    if (!flush && cnt_after_pop != '0)
      head_nxt = mem[rd_next];
    else if (!flush && push)
      head_nxt = wbs_dat_i;
  end

  always_ff @(posedge wb_clk_i) begin
    if (push)
      mem[wr_ptr] <= wbs_dat_i;
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      wbs_ack_o    <= 1'b0;
      wbs_dat_o    <= 32'h0;
      spike_data_o <= 32'h0;
      enable       <= 1'b0;
      overflow     <= 1'b0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
    end else begin
      wbs_ack_o    <= req;
      spike_data_o <= head_nxt;
      if (req)
        wbs_dat_o <= rd_mux;
      if (wr_ctrl)
        enable <= wbs_dat_i[0];
      if (drop)
        overflow <= 1'b1;
      else if (wr_stat && wbs_dat_i[2])
        overflow <= 1'b0;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        wr_ptr <= wr_ptr + AW'(push);
        rd_ptr <= rd_next;
        count  <= count + CW'(push) - CW'(pop);
      end
    end
  end
endmodule

// File: tb/tb_neuron_spike_in.sv
// Directed bench for neuron_spike_in: queue-based reference model checked every cycle,
// plus literal register and stream expectations.
module tb_neuron_spike_in;
  localparam logic [31:0] BASE  = 32'h3000_3000;
  localparam int          DEPTH = 8;
  localparam logic [31:0] A_DATA = BASE + 32'h0;
  localparam logic [31:0] A_STAT = BASE + 32'h4;
  localparam logic [31:0] A_CTRL = BASE + 32'h8;
  localparam logic [31:0] A_DROP = BASE + 32'hC;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [3:0]  sel = 4'h0;
  logic [31:0] adr = 32'h0, dat = 32'h0;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic [31:0] spike_data_o;
  logic        spike_valid_o;
  logic        ready = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  neuron_spike_in #(.BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst_n),
    .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_sel_i(sel),
    .wbs_adr_i(adr), .wbs_dat_i(dat),
    .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
    .spike_data_o(spike_data_o), .spike_valid_o(spike_valid_o),
    .spike_ready_i(ready)
  );

  always #5 clk = ~clk;

  // Reference model: spike queue plus register state, advanced on each rising edge.
  logic [31:0] q[$];
  logic        m_en = 1'b0, m_ovf = 1'b0, m_ack = 1'b0, m_isrd = 1'b0;
  logic [31:0] m_rdat = 32'h0;
  int          m_drop = 0;
  logic [31:0] m_off;
  logic        m_req, m_pop;

  function automatic logic [31:0] model_read(input logic [1:0] idx);
    logic [31:0] v;
    v = 32'h0;
    if (idx == 2'd1)
      v = (q.size() << 4) | (m_ovf ? 32'h4 : 32'h0) | ((q.size() == DEPTH) ? 32'h2 : 32'h0) |
          ((q.size() == 0) ? 32'h1 : 32'h0);
    else if (idx == 2'd2)
      v = {31'h0, m_en};
`ifdef NEURON_SPIKE_IN_DROPCNT_EN
    else if (idx == 2'd3)
      v = m_drop;
`endif
    return v;
  endfunction

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        q.delete(); m_en = 1'b0; m_ovf = 1'b0; m_drop = 0; m_ack = 1'b0; m_isrd = 1'b0; m_rdat = 32'h0;
      end else begin
        m_off = adr - BASE;
        m_req = cyc && stb && (m_off < 32'd16) && !m_ack;
        m_pop = m_en && (q.size() > 0) && ready;
        if (m_req) begin
          m_ack = 1'b1; m_isrd = !we; m_rdat = model_read(m_off[3:2]);
        end else begin
          m_ack = 1'b0;
        end
        if (m_req && we && m_off[3:2] == 2'd1 && dat[0]) begin
          q.delete();
        end else begin
          if (m_pop) void'(q.pop_front());
          if (m_req && we && m_off[3:2] == 2'd0 && sel == 4'hF) begin
            if (q.size() < DEPTH) q.push_back(dat);
            else begin
              m_ovf = 1'b1;
              if (m_drop < 255) m_drop++;
            end
          end
        end
        if (m_req && we && m_off[3:2] == 2'd1 && dat[2] && !(m_off[3:2] == 2'd0)) m_ovf = 1'b0;
        if (m_req && we && m_off[3:2] == 2'd2) m_en = dat[0];
        if (m_req && we && m_off[3:2] == 2'd3) m_drop = 0;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("rst_ack", {31'h0, wbs_ack_o}, 32'h0);
        chk("rst_dat_o", wbs_dat_o, 32'h0);
        chk("rst_valid", {31'h0, spike_valid_o}, 32'h0);
        chk("rst_spike", spike_data_o, 32'h0);
      end else begin
        chk("ack", {31'h0, wbs_ack_o}, {31'h0, m_ack});
        if (m_ack && m_isrd) chk("rdata", wbs_dat_o, m_rdat);
        chk("valid", {31'h0, spike_valid_o}, {31'h0, (m_en && q.size() != 0)});
        if (m_en && q.size() != 0) chk("head", spike_data_o, q[0]);
      end
    end
  end

  task automatic wb_xfer(input logic [31:0] a, input logic w, input logic [31:0] d,
                         input logic [3:0] s, input logic rdy, output logic [31:0] r);
    int k;
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat = d; sel = s; ready = rdy;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!wbs_ack_o && k < 4);
    r = wbs_dat_o;
    cyc = 1'b0; stb = 1'b0; we = 1'b0; ready = 1'b0;
    n_tests++;
    if (!wbs_ack_o) begin
      n_fail++;
      $display("FAIL ack_timeout: adr 0x%08h got no ack expected ack within 4 cycles", a);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] r;
    wb_xfer(a, 1'b1, d, 4'hF, 1'b0, r);
  endtask

  task automatic rd_chk(input string nm, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] r;
    wb_xfer(a, 1'b0, 32'h0, 4'hF, 1'b0, r);
    chk(nm, r, exp);
  endtask

  logic [31:0] tmp;
  logic [31:0] exp_drop;

  initial begin
`ifdef NEURON_SPIKE_IN_DROPCNT_EN
    exp_drop = 32'h1;
`else
    exp_drop = 32'h0;
`endif
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    rd_chk("status_reset", A_STAT, 32'h1);
    rd_chk("ctrl_reset", A_CTRL, 32'h0);

    wr(A_CTRL, 32'h1);
    wr(A_DATA, 32'hA5A5_0001);
    wr(A_DATA, 32'h0000_0002);
    wr(A_DATA, 32'h8000_0003);
    rd_chk("status_cnt3", A_STAT, 32'h30);
    chk("head_first", spike_data_o, 32'hA5A5_0001);
    @(negedge clk);
    ready = 1'b1;
    chk("deliver0", spike_data_o, 32'hA5A5_0001);
    @(negedge clk);
    chk("deliver1", spike_data_o, 32'h0000_0002);
    @(negedge clk);
    chk("deliver2", spike_data_o, 32'h8000_0003);
    @(negedge clk);
    ready = 1'b0;
    chk("drained_valid", {31'h0, spike_valid_o}, 32'h0);
    rd_chk("status_drained", A_STAT, 32'h1);

    // Out-of-window requests on both sides of the register window.
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; sel = 4'hF; adr = BASE + 32'h10; dat = 32'hDEAD;
    repeat (2) @(negedge clk);
    adr = BASE - 32'h4;
    repeat (2) @(negedge clk);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    rd_chk("status_oow", A_STAT, 32'h1);

    for (int i = 0; i < 9; i++) wr(A_DATA, 32'h100 + i);
    rd_chk("status_overflow", A_STAT, 32'h86);
    rd_chk("dropcnt_one", A_DROP, exp_drop);

    wr(A_STAT, 32'h4);
    rd_chk("status_ovf_clr", A_STAT, 32'h82);
    wb_xfer(A_DATA, 1'b1, 32'h777, 4'hF, 1'b1, tmp);
    rd_chk("status_full_pushpop", A_STAT, 32'h82);

    wr(A_CTRL, 32'h0);
    chk("disable_valid", {31'h0, spike_valid_o}, 32'h0);
    ready = 1'b1;
    repeat (3) @(negedge clk);
    ready = 1'b0;
    rd_chk("status_retained", A_STAT, 32'h82);
    wr(A_CTRL, 32'h1);

    wb_xfer(A_STAT, 1'b1, 32'h1, 4'hF, 1'b1, tmp);
    rd_chk("status_flush_pop", A_STAT, 32'h1);
    for (int i = 0; i < 4; i++) wr(A_DATA, 32'h200 + i);
    rd_chk("status_cnt4", A_STAT, 32'h40);
    wr(A_STAT, 32'h1);
    chk("flush_valid", {31'h0, spike_valid_o}, 32'h0);
    rd_chk("status_flushed", A_STAT, 32'h1);
    wb_xfer(A_DATA, 1'b1, 32'h1234, 4'h3, 1'b0, tmp);
    rd_chk("status_partial", A_STAT, 32'h1);

    // Streaming with the core always ready, exercising pointer wrap.
    for (int i = 0; i < 12; i++) begin
      wb_xfer(A_DATA, 1'b1, 32'h300 + i, 4'hF, 1'b1, tmp);
      @(negedge clk);
      ready = 1'b1;
    end
    repeat (2) @(negedge clk);
    ready = 1'b0;
    rd_chk("status_stream", A_STAT, 32'h1);

    for (int i = 0; i < 5; i++) wr(A_DATA, 32'h400 + i);
    rd_chk("status_cnt5", A_STAT, 32'h50);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = A_STAT;
    #2 rst_n = 1'b0;
    cyc = 1'b0; stb = 1'b0;
    @(negedge clk);
    chk("reset_abort_ack", {31'h0, wbs_ack_o}, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rd_chk("status_after_rst", A_STAT, 32'h1);
    rd_chk("ctrl_after_rst", A_CTRL, 32'h0);
    wr(A_DROP, 32'h55);
    rd_chk("dropcnt_write", A_DROP, 32'h0);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit expected completion");
    $fatal(1, "watchdog");
  end
endmodule
